// File: rtl/vga_sync_color_gen.sv
// vga_sync_color_gen
//   Parametrised VGA timing and colour generator. A mod-DIV divider produces
//   the pixel strobe, which advances the horizontal/vertical counters. The
//   sync, active-video and colour outputs are registered on that strobe from
//   the decode of the current position, so they trail qh/qv by one pixel.
//   Three push-buttons are synchronised and debounced, and each accepted
//   press toggles its colour channel enable.
//
// Ports
//   reloj                    system clock
//   resetM                   asynchronous active-low reset
//   boton_r/g/b              raw active-high push-buttons
//   bit_fuente               font/mosaic bit for the current qh/qv
//   qh, qv                   pixel / line counters
//   pixel_tick               one-cycle strobe every DIV cycles
//   frame_start              strobe on the tick that wraps to (0,0)
//   h_sync, v_sync           registered syncs, asserted level SYNC_POL
//   video_on                 registered active-video flag
//   r, g, b                  registered colour channels
module vga_sync_color_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int DIV        = 4,
  parameter int COLOR_W    = 4,
  parameter int CNT_W      = 10,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic               reloj,
  input  logic               resetM,
  input  logic               boton_r,
  input  logic               boton_g,
  input  logic               boton_b,
  input  logic               bit_fuente,
  output logic [CNT_W-1:0]   qh,
  output logic [CNT_W-1:0]   qv,
  output logic               pixel_tick,
  output logic               frame_start,
  output logic               h_sync,
  output logic               v_sync,
  output logic               video_on,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEB_W    = $clog2(DEB_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Window test done in int so an end bound equal to the total still fits.
  function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction

  function automatic logic sync_level(input logic active);
    return active ? SYNC_POL : ~SYNC_POL;
  endfunction

  function automatic logic [COLOR_W-1:0] channel_fill(input logic on);
    return {COLOR_W{on}};
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             h_last;
  logic             v_last;
  logic             hs_d;
  logic             vs_d;
  logic             von_d;
  logic             lit_d;

  logic [2:0]       btn_raw;
  logic [2:0]       btn_meta;
  logic [2:0]       btn_sync;
  logic [2:0]       btn_acc;
  logic [2:0]       en;
  logic [DEB_W-1:0] deb_cnt [3];

  // Gated by resetM so the strobe is low while reset is held, even at DIV=1.
  assign pixel_tick  = resetM && (div_cnt == DIV_LAST);
  assign h_last      = (qh == H_LAST);
  assign v_last      = (qv == V_LAST);
  assign frame_start = pixel_tick && h_last && v_last;

  assign hs_d  = in_window(qh, HS_START, HS_END);
  assign vs_d  = in_window(qv, VS_START, VS_END);
  assign von_d = in_window(qh, 0, H_ACTIVE) && in_window(qv, 0, V_ACTIVE);
  assign lit_d = von_d && bit_fuente;

  assign btn_raw = {boton_b, boton_g, boton_r};

  // Stage p0: pixel divider and position counters
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      div_cnt <= '0;
      qh      <= '0;
      qv      <= '0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (pixel_tick) begin
        if (h_last) begin
          qh <= '0;
          qv <= v_last ? '0 : qv + 1'b1;
        end else begin
          qh <= qh + 1'b1;
        end
      end
    end
  end

  // Stage p1: outputs registered from the pre-advance decode
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      h_sync   <= ~SYNC_POL;
      v_sync   <= ~SYNC_POL;
      video_on <= 1'b0;
      r        <= '0;
      g        <= '0;
      b        <= '0;
    end else if (pixel_tick) begin
      h_sync   <= sync_level(hs_d);
      v_sync   <= sync_level(vs_d);
      video_on <= von_d;
      r        <= channel_fill(lit_d && en[0]);
      g        <= channel_fill(lit_d && en[1]);
      b        <= channel_fill(lit_d && en[2]);
    end
  end

  // Button path: two-flop synchroniser, then a per-channel mismatch counter.
  // The accepted level flips after DEB_CYCLES consecutive mismatches; only
  // a flip to 1 toggles the channel enable.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_acc  <= '0;
      en       <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      for (int i = 0; i < 3; i++) begin
        if (btn_sync[i] != btn_acc[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            btn_acc[i] <= btn_sync[i];
            deb_cnt[i] <= '0;
            if (btn_sync[i]) begin
              en[i] <= ~en[i];
            end
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_color_gen.sv
// tb_vga_sync_color_gen
//   Directed bench for vga_sync_color_gen with a small 14x7 raster. A pixel
//   count model predicts every output each cycle; literal expectations pin
//   reset values, first-tick latency, per-frame window sizes and the
//   button/enable behaviour.
`timescale 1ns/1ps
module tb_vga_sync_color_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int DIV      = 2;
  localparam int COLOR_W  = 4;
  localparam int CNT_W    = 10;
  localparam int DEB      = 4;
  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic               clk = 1'b0;
  logic               resetM;
  logic               boton_r, boton_g, boton_b;
  logic               bit_fuente;
  logic [CNT_W-1:0]   qh, qv;
  logic               pixel_tick, frame_start, h_sync, v_sync, video_on;
  logic [COLOR_W-1:0] r, g, b;

  vga_sync_color_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0), .DIV(DIV), .COLOR_W(COLOR_W), .CNT_W(CNT_W),
    .DEB_CYCLES(DEB)
  ) dut (
    .reloj(clk), .resetM(resetM),
    .boton_r(boton_r), .boton_g(boton_g), .boton_b(boton_b),
    .bit_fuente(bit_fuente),
    .qh(qh), .qv(qv), .pixel_tick(pixel_tick), .frame_start(frame_start),
    .h_sync(h_sync), .v_sync(v_sync), .video_on(video_on),
    .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  bit font_mode = 1'b0;

  function automatic int hpos(input int p);
    return p % HT;
  endfunction

  function automatic int vpos(input int p);
    return (p / HT) % VT;
  endfunction

  function automatic logic font_val(input bit mode, input int h, input int v);
    return mode ? (((h + 2 * v) % 3) != 0) : 1'b1;
  endfunction

  // ---------------- behavioural model ----------------
  int                 pcount;   // pixels consumed since reset release
  int                 dph;      // reloj cycles into the current pixel
  logic [2:0]         m_en;
  logic [2:0]         m_acc;
  logic [DEB:0]       hist [3]; // bit j = button sample taken j+1 edges ago
  logic               m_hs, m_vs, m_von;
  logic [COLOR_W-1:0] m_col [3];
  logic [2:0]         btn_vec;

  assign btn_vec    = {boton_b, boton_g, boton_r};
  assign bit_fuente = font_val(font_mode, hpos(pcount), vpos(pcount));

  always @(posedge clk or negedge resetM) begin
    if (!resetM) begin
      pcount <= 0;
      dph    <= 0;
      m_en   <= 3'b111;
      m_acc  <= 3'b000;
      m_hs   <= 1'b1;
      m_vs   <= 1'b1;
      m_von  <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        hist[c]  <= '0;
        m_col[c] <= '0;
      end
    end else begin
      if (dph == DIV - 1) begin
        m_hs  <= (hpos(pcount) >= H_ACTIVE + H_FP && hpos(pcount) < H_ACTIVE + H_FP + H_SYNC) ? 1'b0 : 1'b1;
        m_vs  <= (vpos(pcount) >= V_ACTIVE + V_FP && vpos(pcount) < V_ACTIVE + V_FP + V_SYNC) ? 1'b0 : 1'b1;
        m_von <= (hpos(pcount) < H_ACTIVE) && (vpos(pcount) < V_ACTIVE);
        for (int c = 0; c < 3; c++) begin
          m_col[c] <= {COLOR_W{(hpos(pcount) < H_ACTIVE) && (vpos(pcount) < V_ACTIVE) &&
                               font_val(font_mode, hpos(pcount), vpos(pcount)) && m_en[c]}};
        end
        pcount <= pcount + 1;
      end
      dph <= (dph + 1) % DIV;
      // A level is accepted once the synchronised samples (two edges old)
      // have disagreed with it for DEB consecutive edges.
      for (int c = 0; c < 3; c++) begin
        if (hist[c][DEB:1] == {DEB{~m_acc[c]}}) begin
          m_acc[c] <= ~m_acc[c];
          if (!m_acc[c]) m_en[c] <= ~m_en[c];
        end
        hist[c] <= {hist[c][DEB-1:0], btn_vec[c]};
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_for(input int which, input int limit, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = (video_on === 1'b1);
        1:       hit = (frame_start === 1'b1);
        default: hit = (qh == 5) && (qv == 2);
      endcase
    end
    if (!hit) begin
      nchk++;
      nerr++;
      $display("FAIL %s timeout after %0d cycles", name, limit);
    end
  endtask

  task automatic press(input logic [2:0] which, input int cycles);
    @(posedge clk);
    #2 {boton_b, boton_g, boton_r} = which;
    repeat (cycles) @(posedge clk);
    #2 {boton_b, boton_g, boton_r} = 3'b000;
    repeat (12) @(posedge clk);
  endtask

  logic [36:0] exp_v, got_v;
  logic        e_tick, e_fs;
  int          hs_low, vs_low, von_cnt, rf_cnt, fs_cnt;

  initial begin
    fork
      // Per-cycle comparison against the model.
      forever begin
        @(negedge clk);
        e_tick = (resetM === 1'b1) && (dph == DIV - 1);
        e_fs   = e_tick && (hpos(pcount) == HT - 1) && (vpos(pcount) == VT - 1);
        exp_v  = {CNT_W'(hpos(pcount)), CNT_W'(vpos(pcount)), e_tick, e_fs,
                  m_hs, m_vs, m_von, m_col[0], m_col[1], m_col[2]};
        got_v  = {qh, qv, pixel_tick, frame_start, h_sync, v_sync, video_on, r, g, b};
        nchk++;
        if (got_v !== exp_v) begin
          nerr++;
          $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, got_v, exp_v);
        end
      end
      begin
        resetM = 1'b1;
        {boton_b, boton_g, boton_r} = 3'b000;
        #1 resetM = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_qh", 64'(qh), 64'd0);
        check("rst_qv", 64'(qv), 64'd0);
        check("rst_hsync", 64'(h_sync), 64'd1);
        check("rst_vsync", 64'(v_sync), 64'd1);
        check("rst_video_on", 64'(video_on), 64'd0);
        check("rst_rgb", 64'({r, g, b}), 64'd0);
        check("rst_tick", 64'(pixel_tick), 64'd0);

        @(negedge clk);
        #2 resetM = 1'b1;
        @(negedge clk);
        #1 check("first_tick_high", 64'(pixel_tick), 64'd1);
        check("first_tick_qh0", 64'(qh), 64'd0);
        @(negedge clk);
        #1 check("second_cycle_tick_low", 64'(pixel_tick), 64'd0);
        check("second_cycle_qh1", 64'(qh), 64'd1);

        // One full frame of outputs following a frame_start strobe.
        wait_for(1, 400, "wait_frame_start");
        hs_low = 0; vs_low = 0; von_cnt = 0; rf_cnt = 0; fs_cnt = 0;
        repeat (HT * VT * DIV) begin
          @(negedge clk);
          if (h_sync === 1'b0) hs_low++;
          if (v_sync === 1'b0) vs_low++;
          if (video_on === 1'b1) von_cnt++;
          if (r === 4'hF) rf_cnt++;
          if (frame_start === 1'b1) fs_cnt++;
        end
        check("frame_hsync_low_cycles", 64'(hs_low), 64'd28);
        check("frame_vsync_low_cycles", 64'(vs_low), 64'd28);
        check("frame_video_on_cycles", 64'(von_cnt), 64'd64);
        check("frame_red_full_cycles", 64'(rf_cnt), 64'd64);
        check("frame_start_pulses", 64'(fs_cnt), 64'd1);

        press(3'b010, 3);
        wait_for(0, 400, "wait_active_glitch");
        check("glitch_keeps_g", 64'(g), 64'hF);

        press(3'b010, 10);
        wait_for(0, 400, "wait_active_g_off");
        check("g_disabled", 64'(g), 64'h0);
        check("r_still_on", 64'(r), 64'hF);
        check("b_still_on", 64'(b), 64'hF);

        press(3'b010, 10);
        wait_for(0, 400, "wait_active_g_on");
        check("g_reenabled", 64'(g), 64'hF);

        press(3'b010, 10);
        wait_for(2, 400, "wait_qh5_qv2");
        check("pre_reset_g_off", 64'(g), 64'h0);
        check("pre_reset_r_on", 64'(r), 64'hF);
        #2 resetM = 1'b0;
        #1;
        check("async_rst_qh", 64'(qh), 64'd0);
        check("async_rst_qv", 64'(qv), 64'd0);
        check("async_rst_syncs", 64'({h_sync, v_sync}), 64'd3);
        check("async_rst_video_on", 64'(video_on), 64'd0);
        check("async_rst_rgb", 64'({r, g, b}), 64'd0);
        check("async_rst_strobes", 64'({pixel_tick, frame_start}), 64'd0);
        @(negedge clk);
        #2 resetM = 1'b1;
        wait_for(0, 400, "wait_active_after_reset");
        check("after_reset_g_on", 64'(g), 64'hF);

        font_mode = 1'b1;
        repeat (250) @(posedge clk);
        font_mode = 1'b0;

        press(3'b111, 10);
        wait_for(0, 400, "wait_active_all_off");
        check("all_toggled_off", 64'({r, g, b}), 64'd0);
        repeat (250) @(posedge clk);
      end
    join_any
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
